md5_block_engine: RTL
=====================

# md5_block_engine

Sequential MD5 compression engine: accepts one padded 512-bit block as 16 little-endian 32-bit words over a valid/ready stream, runs the 64 MD5 steps at one step per clock, and returns the 128-bit chaining value. It drives its own step datapath from internal step counter, shift-amount, T-constant and message-index tables, so it is the producer of every `a/b/c/d/message/s/t/rnd` operand a single MD5 step consumes. It sits between the padding/word-packing front end and the digest consumer in the hashing pipeline.

## Interface
- `IV_A`, default 32'h67452301, initial chaining word A
- `IV_B`, default 32'hefcdab89, initial chaining word B
- `IV_C`, default 32'h98badcfe, initial chaining word C
- `IV_D`, default 32'h10325476, initial chaining word D

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  `in_word` valid
- `in_ready`  out  1  engine accepts a word this cycle
- `in_word`  in  32  message word M[k], k = 0..15 in arrival order
- `in_first`  in  1  sampled with word 0; 1 = start from IV (used only with `MD5_CHAIN_EN`)
- `busy`  out  1  high from word 0 accepted until digest handed off
- `dig_valid`  out  1  `digest` valid
- `dig_ready`  in  1  consumer accepts digest
- `digest`  out  128  {D,C,B,A}; A in bits 31:0

## Operation
- FSM states: LOAD, RUN, FINAL, OUT.
- LOAD: `in_ready`=1; word accepted when `in_valid & in_ready`; stored into M[cnt], cnt 0→15. On word 0, working regs A,B,C,D ← chaining value (see Configuration). After word 15 accepted → RUN, step i=0.
- RUN: one step per cycle, i = 0..63. rnd = i[5:4].
  - f: rnd0 (B&C)|(~B&D); rnd1 (B&D)|(C&~D); rnd2 B^C^D; rnd3 C^(B|~D).
  - g: rnd0 i; rnd1 (5i+1) mod 16; rnd2 (3i+5) mod 16; rnd3 7i mod 16.
  - s: rnd0 {7,12,17,22}; rnd1 {5,9,14,20}; rnd2 {4,11,16,23}; rnd3 {6,10,15,21}, indexed by i[1:0].
  - T[i] = floor(|sin(i+1)|·2^32), 64-entry constant ROM.
  - tmp = B + rotl32(A + f + M[g] + T[i], s); all sums mod 2^32.
  - (A,B,C,D) ← (D, tmp, B, C). After i=63 → FINAL.
- FINAL: chaining H ← H + {A,B,C,D} word-wise mod 2^32 → OUT.
- OUT: `dig_valid`=1, `digest`=H held stable; on `dig_valid & dig_ready` → LOAD.
- `in_ready`=0 in RUN, FINAL, OUT; words offered then are not consumed.

## Timing
- Reset values: `in_ready`=1 (LOAD after reset), `busy`=0, `dig_valid`=0, `digest`=0, cnt=0, i=0, H={IV_D,IV_C,IV_B,IV_A}.
- Word 15 accepted at edge N: RUN steps at edges N+1..N+64, FINAL at N+65, `dig_valid` high from N+65 (visible in cycle after edge N+65). Latency last word → digest = 65 cycles; block throughput 16+64+1+1 = 82 cycles minimum.
- `dig_ready` held low: `dig_valid` and `digest` stay constant indefinitely.
- Handoff edge returns to LOAD; `in_ready` high next cycle (no same-cycle word acceptance in OUT).
- `in_valid` gaps during LOAD stall cnt; no timeout.
- `rst` in any state: returns to LOAD next edge, partial block discarded, H←IV, outputs to reset values.

## Configuration
- `MD5_CHAIN_EN` defined: H persists across blocks; `in_first`=1 on word 0 reloads H←IV before loading A..D; `in_first`=0 continues from prior digest (multi-block messages).
- Undefined: `in_first` ignored; every block starts from IV; each digest is a standalone single-block MD5.

## Test plan
- "abc" block: M0=32'h80636261, M14=32'h18, others 0, `in_first`=1 → `digest`={32'h727fe128,32'h7d3f96d6,32'hb04fd23c,32'h98500190}, `dig_valid` 65 cycles after word 15.
- Empty message: M0=32'h00000080, others 0 → `digest`={32'h7e42f8ec,32'h980980e9,32'h04b2008f,32'hd98c1dd4}.
- Backpressure: `in_valid` toggling every other cycle during LOAD, `dig_ready` low 20 cycles in OUT → same "abc" digest, stable throughout, `in_ready`=0 while OUT.
- Reset at RUN step 30, then full "abc" block → correct "abc" digest; no output from aborted block.
- Two "abc" blocks back-to-back, second `in_first`=0: without `MD5_CHAIN_EN` both digests equal "abc" value; with it the second digest differs and equals model of IV→"abc"→"abc" chaining.
- Back-to-back "abc" then empty with `in_first`=1 both → both reference digests, each exactly 82 cycles apart with zero-stall stimulus.

Source files
------------

// File: rtl/md5_block_engine_if.sv
// Stream-side signals of md5_block_engine: word input handshake and digest output handshake.
interface md5_block_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_word;
  logic         in_first;
  logic         busy;
  logic         dig_valid;
  logic         dig_ready;
  logic [127:0] digest;

  modport master (
    output in_valid, in_word, in_first, dig_ready,
    input  in_ready, busy, dig_valid, digest
  );

  modport slave (
    input  in_valid, in_word, in_first, dig_ready,
    output in_ready, busy, dig_valid, digest
  );
endinterface

// File: rtl/md5_block_engine.sv
// Sequential MD5 compression: loads 16 words, runs 64 steps at one per clock, emits {D,C,B,A}.
// Optional MD5_CHAIN_EN keeps the chaining value across blocks, with in_first restarting from IV.
module md5_block_engine #(
  parameter logic [31:0] IV_A = 32'h67452301,
  parameter logic [31:0] IV_B = 32'hefcdab89,
  parameter logic [31:0] IV_C = 32'h98badcfe,
  parameter logic [31:0] IV_D = 32'h10325476
) (
  input logic                clk,
  input logic                rst,
  md5_block_engine_if.slave  bus
);

  typedef enum logic [1:0] {LOAD, RUN, FINAL, OUT} state_t;

  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,  5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,  5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [31:0] t_rom(input logic [5:0] idx);
    logic [31:0] t;
    case (idx)
      6'd0:  t = 32'hd76aa478; 6'd1:  t = 32'he8c7b756; 6'd2:  t = 32'h242070db; 6'd3:  t = 32'hc1bdceee;
      6'd4:  t = 32'hf57c0faf; 6'd5:  t = 32'h4787c62a; 6'd6:  t = 32'ha8304613; 6'd7:  t = 32'hfd469501;
      6'd8:  t = 32'h698098d8; 6'd9:  t = 32'h8b44f7af; 6'd10: t = 32'hffff5bb1; 6'd11: t = 32'h895cd7be;
      6'd12: t = 32'h6b901122; 6'd13: t = 32'hfd987193; 6'd14: t = 32'ha679438e; 6'd15: t = 32'h49b40821;
      6'd16: t = 32'hf61e2562; 6'd17: t = 32'hc040b340; 6'd18: t = 32'h265e5a51; 6'd19: t = 32'he9b6c7aa;
      6'd20: t = 32'hd62f105d; 6'd21: t = 32'h02441453; 6'd22: t = 32'hd8a1e681; 6'd23: t = 32'he7d3fbc8;
      6'd24: t = 32'h21e1cde6; 6'd25: t = 32'hc33707d6; 6'd26: t = 32'hf4d50d87; 6'd27: t = 32'h455a14ed;
      6'd28: t = 32'ha9e3e905; 6'd29: t = 32'hfcefa3f8; 6'd30: t = 32'h676f02d9; 6'd31: t = 32'h8d2a4c8a;
      6'd32: t = 32'hfffa3942; 6'd33: t = 32'h8771f681; 6'd34: t = 32'h6d9d6122; 6'd35: t = 32'hfde5380c;
      6'd36: t = 32'ha4beea44; 6'd37: t = 32'h4bdecfa9; 6'd38: t = 32'hf6bb4b60; 6'd39: t = 32'hbebfbc70;
      6'd40: t = 32'h289b7ec6; 6'd41: t = 32'heaa127fa; 6'd42: t = 32'hd4ef3085; 6'd43: t = 32'h04881d05;
      6'd44: t = 32'hd9d4d039; 6'd45: t = 32'he6db99e5; 6'd46: t = 32'h1fa27cf8; 6'd47: t = 32'hc4ac5665;
      6'd48: t = 32'hf4292244; 6'd49: t = 32'h432aff97; 6'd50: t = 32'hab9423a7; 6'd51: t = 32'hfc93a039;
      6'd52: t = 32'h655b59c3; 6'd53: t = 32'h8f0ccc92; 6'd54: t = 32'hffeff47d; 6'd55: t = 32'h85845dd1;
      6'd56: t = 32'h6fa87e4f; 6'd57: t = 32'hfe2ce6e0; 6'd58: t = 32'ha3014314; 6'd59: t = 32'h4e0811a1;
      6'd60: t = 32'hf7537e82; 6'd61: t = 32'hbd3af235; 6'd62: t = 32'h2ad7d2bb; default: t = 32'heb86d391;
    endcase
    return t;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] m_q [16];
  logic [3:0]  cnt_q;
  logic [5:0]  step_q;
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [31:0] ha_q, hb_q, hc_q, hd_q;

  logic        in_ready, dig_valid, accept, reload;
  logic [1:0]  rnd;
  logic [3:0]  i4, g;
  logic [4:0]  s;
  logic [31:0] f, sum, rot, tmp;

  assign accept = in_ready & bus.in_valid;

`ifdef MD5_CHAIN_EN
  assign reload = bus.in_first;
`else
  logic in_first_unused;
  assign in_first_unused = bus.in_first;
  assign reload          = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    dig_valid = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && cnt_q == 4'd15) state_d = RUN;
      end
      RUN:   if (step_q == 6'd63) state_d = FINAL;
      FINAL: state_d = OUT;
      OUT: begin
        dig_valid = 1'b1;
        if (bus.dig_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Step datapath: round function, message index and rotate amount all derive from step_q.
  assign rnd = step_q[5:4];
  assign i4  = step_q[3:0];
  assign s   = S_TAB[{rnd, step_q[1:0]}];

  always_comb begin
    f = '0;
    g = '0;
    case (rnd)
      2'd0: begin f = (b_q & c_q) | (~b_q & d_q); g = i4;                end
      2'd1: begin f = (b_q & d_q) | (c_q & ~d_q); g = i4 * 4'd5 + 4'd1;  end
      2'd2: begin f = b_q ^ c_q ^ d_q;            g = i4 * 4'd3 + 4'd5;  end
      default: begin f = c_q ^ (b_q | ~d_q);      g = i4 * 4'd7;         end
    endcase
  end

  assign sum = a_q + f + m_q[g] + t_rom(step_q);
  assign rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
  assign tmp = b_q + rot;

  // NOTE: the message store carries no reset; every word is written before any step reads it.
  always_ff @(posedge clk) begin
    if (accept) m_q[cnt_q] <= bus.in_word;
  end

  // NOTE: sequential state uses non-blocking assignments so the step rotation reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      ha_q   <= IV_A;
      hb_q   <= IV_B;
      hc_q   <= IV_C;
      hd_q   <= IV_D;
    end else begin
      case (state_q)
        LOAD: if (accept) begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd0) begin
            if (reload) begin
              ha_q <= IV_A; hb_q <= IV_B; hc_q <= IV_C; hd_q <= IV_D;
              a_q  <= IV_A; b_q  <= IV_B; c_q  <= IV_C; d_q  <= IV_D;
            end else begin
              a_q <= ha_q; b_q <= hb_q; c_q <= hc_q; d_q <= hd_q;
            end
          end
        end
        RUN: begin
          a_q    <= d_q;
          b_q    <= tmp;
          c_q    <= b_q;
          d_q    <= c_q;
          step_q <= step_q + 6'd1;
        end
        FINAL: begin
          ha_q <= ha_q + a_q;
          hb_q <= hb_q + b_q;
          hc_q <= hc_q + c_q;
          hd_q <= hd_q + d_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.dig_valid = dig_valid;
  assign bus.busy      = (state_q != LOAD) || (cnt_q != 4'd0);
  assign bus.digest    = dig_valid ? {hd_q, hc_q, hb_q, ha_q} : '0;

endmodule
